prince_sbox_layer_ts: RTL and testbench

PRINCE_SBOX_LAYER_TS -- requirements
Module: prince_sbox_layer_ts

---
 rtl/prince_sbox_pkg.sv | 41 ++++
 rtl/prince_sbox_ts_ch.sv | 48 ++++
 rtl/prince_sbox_layer_ts.sv | 122 ++++++++++++
 tb/tb_prince_sbox_layer_ts.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prince_sbox_pkg.sv
// Shared constants and helpers for the two-share PRINCE S-box layer:
// S-box table, nibble/randomness widths and the monomial ordering of the expansion.
package prince_sbox_pkg;

    localparam int NIB_W     = 4;
    localparam int RW_PER_CH = 18;
    localparam int NMONO     = 14;

    // Entry i sits at bits [4i+3:4i]: S = {B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4}.
    localparam logic [63:0] SBOX_TABLE = 64'h4D5E_0876_19CA_23FB;

    // Monomial k selects the variables in nibble k (x = bit 3 ... w = bit 0):
    // x,y,z,w,xy,xz,xw,yz,yw,zw,xyz,xyw,xzw,yzw from k = 0 upwards.
    localparam logic [NMONO*NIB_W-1:0] MONO_MASKS = 56'h7BDE_3569_AC12_48;

    function automatic logic [NIB_W-1:0] sbox(input logic [NIB_W-1:0] x);
        return SBOX_TABLE[{x, 2'b00} +: NIB_W];
    endfunction

    function automatic logic [NIB_W-1:0] mono_mask(input int k);
        return MONO_MASKS[k*NIB_W +: NIB_W];
    endfunction

    function automatic logic mono_eval(input logic [NIB_W-1:0] v, input logic [NIB_W-1:0] m);
        return &(v | ~m);
    endfunction

    // Coefficient of monomial m in a -> S(a ^ b), as a function of b (Moebius transform).
    function automatic logic [NIB_W-1:0] anf_coef(input logic [NIB_W-1:0] b,
                                                  input logic [NIB_W-1:0] m);
        logic [NIB_W-1:0] acc;
        logic [NIB_W-1:0] tn;
        acc = '0;
        for (int t = 0; t < 16; t++) begin
            tn = t[NIB_W-1:0];
            if ((tn & ~m) == 4'd0) acc = acc ^ sbox(tn ^ b);
        end
        return acc;
    endfunction

endpackage

// File: rtl/prince_sbox_ts_ch.sv
// One S-box channel: stage-1 monomial expansion of share 1 plus share-2 refresh,
// and stage-2 recombination of those (registered elsewhere) back into two shares.
module prince_sbox_ts_ch
    import prince_sbox_pkg::*;
(
    input  logic [NIB_W-1:0]     i_share1,
    input  logic [NIB_W-1:0]     i_share2,
    input  logic [RW_PER_CH-1:0] i_rand,
    output logic [NMONO-1:0]     o_s1_p1,
    output logic [NMONO-1:0]     o_s1_p2,
    output logic [NIB_W-1:0]     o_s1_b,
    input  logic [NMONO-1:0]     i_s1_p1,
    input  logic [NMONO-1:0]     i_s1_p2,
    input  logic [NIB_W-1:0]     i_s1_b,
    output logic [NIB_W-1:0]     o_share1,
    output logic [NIB_W-1:0]     o_share2
);

    logic [NIB_W-1:0] w_r_hi;
    logic [NIB_W-1:0] w_a;
    logic [NIB_W-1:0] w_coef;

    // Both shares get the same refresh nibble so their XOR is unchanged.
    always_comb begin
        w_r_hi = i_rand[RW_PER_CH-1 -: NIB_W];
        w_a    = i_share1 ^ w_r_hi;
        o_s1_b = i_share2 ^ w_r_hi;
        o_s1_p1 = '0;
        o_s1_p2 = '0;
        for (int k = 0; k < NMONO; k++) begin
            o_s1_p1[k] = mono_eval(w_a, mono_mask(k)) ^ i_rand[k];
            o_s1_p2[k] = i_rand[k];
        end
    end

    // S(a^b) = c0(b) ^ sum_M a^M * cM(b); the degree-4 term is zero for a bijection.
    always_comb begin
        o_share1 = anf_coef(i_s1_b, 4'd0);
        o_share2 = '0;
        w_coef   = '0;
        for (int k = 0; k < NMONO; k++) begin
            w_coef   = anf_coef(i_s1_b, mono_mask(k));
            o_share1 = o_share1 ^ ({NIB_W{i_s1_p1[k]}} & w_coef);
            o_share2 = o_share2 ^ ({NIB_W{i_s1_p2[k]}} & w_coef);
        end
    end

endmodule

// File: rtl/prince_sbox_layer_ts.sv
// Two-stage masked PRINCE S-box layer with valid/ready on both sides.
// Define PRINCE_SBOX_IDLE_CLR_EN to zero the share flops of any stage that goes idle.
module prince_sbox_layer_ts
    import prince_sbox_pkg::*;
#(
    parameter int NCH = 16,
    parameter int RW  = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NCH-1:0]  in_share1,
    input  logic [4*NCH-1:0]  in_share2,
    input  logic [RW*NCH-1:0] rand_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NCH-1:0]  out_share1,
    output logic [4*NCH-1:0]  out_share2,
    output logic              busy
);

    generate
        if (RW != RW_PER_CH) begin : g_bad_rw
            $error("prince_sbox_layer_ts: RW must be 18");
        end
    endgenerate

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    logic r_v1;
    logic r_v2;
    logic w_acc;
    logic w_adv2;
    logic w_v1_nxt;
    logic w_v2_nxt;

    logic [NMONO-1:0] r_s1_p1 [NCH];
    logic [NMONO-1:0] r_s1_p2 [NCH];
    logic [NIB_W-1:0] r_s1_b  [NCH];
    logic [4*NCH-1:0] r_out1;
    logic [4*NCH-1:0] r_out2;

    logic [NMONO-1:0] w_s1_p1 [NCH];
    logic [NMONO-1:0] w_s1_p2 [NCH];
    logic [NIB_W-1:0] w_s1_b  [NCH];
    logic [4*NCH-1:0] w_out1;
    logic [4*NCH-1:0] w_out2;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_ch
            prince_sbox_ts_ch u_ch (
                .i_share1 (in_share1[NIB_W*g +: NIB_W]),
                .i_share2 (in_share2[NIB_W*g +: NIB_W]),
                .i_rand   (rand_in[RW*g +: RW]),
                .o_s1_p1  (w_s1_p1[g]),
                .o_s1_p2  (w_s1_p2[g]),
                .o_s1_b   (w_s1_b[g]),
                .i_s1_p1  (r_s1_p1[g]),
                .i_s1_p2  (r_s1_p2[g]),
                .i_s1_b   (r_s1_b[g]),
                .o_share1 (w_out1[NIB_W*g +: NIB_W]),
                .o_share2 (w_out2[NIB_W*g +: NIB_W])
            );
        end
    endgenerate

    always_comb begin
        in_ready = !r_v1 || !r_v2 || out_ready;
        w_acc    = in_valid && in_ready;
        w_adv2   = r_v1 && (!r_v2 || out_ready);
        w_v1_nxt = w_acc || (r_v1 && !w_adv2);
        w_v2_nxt = w_adv2 || (r_v2 && !out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_out1 <= '0;
            r_out2 <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_s1_p1[i] <= '0;
                r_s1_p2[i] <= '0;
                r_s1_b[i]  <= '0;
            end
        end else begin
            r_v1 <= w_v1_nxt;
            r_v2 <= w_v2_nxt;
            for (int i = 0; i < NCH; i++) begin
                if (w_acc) begin
                    r_s1_p1[i] <= w_s1_p1[i];
                    r_s1_p2[i] <= w_s1_p2[i];
                    r_s1_b[i]  <= w_s1_b[i];
                end
`ifdef PRINCE_SBOX_IDLE_CLR_EN
                else if (!w_v1_nxt) begin
                    r_s1_p1[i] <= '0;
                    r_s1_p2[i] <= '0;
                    r_s1_b[i]  <= '0;
                end
`endif
            end
            if (w_adv2) begin
                r_out1 <= w_out1;
                r_out2 <= w_out2;
            end
`ifdef PRINCE_SBOX_IDLE_CLR_EN
            else if (!w_v2_nxt) begin
                r_out1 <= '0;
                r_out2 <= '0;
            end
`endif
        end
    end

    assign out_valid  = r_v2;
    assign out_share1 = r_out1;
    assign out_share2 = r_out2;
    assign busy       = r_v1 || r_v2;

endmodule

// File: tb/tb_prince_sbox_layer_ts.sv
// Scoreboarded bench for prince_sbox_layer_ts: directed vectors, sweep, backpressure, reset.
module tb_prince_sbox_layer_ts;

    localparam int NCH = 16;
    localparam int RW  = 18;
    localparam int W   = 4*NCH;
    localparam int RT  = RW*NCH;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_share1;
    logic [W-1:0]  in_share2;
    logic [RT-1:0] rand_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_share1;
    logic [W-1:0]  out_share2;
    logic          busy;

    prince_sbox_layer_ts #(.NCH(NCH), .RW(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_share1  (in_share1),
        .in_share2  (in_share2),
        .rand_in    (rand_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_share1 (out_share1),
        .out_share2 (out_share2),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_exp;
    logic [W-1:0] last_o1, last_o2;
    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int n_out    = 0;

    logic [3:0] tb_sbox [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                 4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};

    function automatic logic [W-1:0] model(input logic [W-1:0] s1, input logic [W-1:0] s2);
        logic [W-1:0] r;
        logic [W-1:0] x;
        x = s1 ^ s2;
        r = '0;
        for (int i = 0; i < NCH; i++) r[4*i +: 4] = tb_sbox[x[4*i +: 4]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: transfers are decided by values stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                last_o1 = out_share1;
                last_o2 = out_share2;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_out: got %h, expected no output", out_share1 ^ out_share2);
                end else begin
                    chk("data", out_share1 ^ out_share2, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                n_acc++;
                exp_q.push_back(cur_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [RT-1:0] rnd_vec();
        logic [RT-1:0] r;
        r = '0;
        for (int k = 0; k < RT; k += 32) r[k +: 32] = $urandom();
        return r;
    endfunction

    // Called at posedge+#1; returns at posedge+#1 of the accepting edge.
    task automatic send(input logic [W-1:0] s1, input logic [W-1:0] s2,
                        input logic [RT-1:0] rnd, input logic [W-1:0] e);
        int waited;
        bit done;
        waited = 0;
        done = 0;
        in_valid  = 1'b1;
        in_share1 = s1;
        in_share2 = s2;
        rand_in   = rnd;
        cur_exp   = e;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            else begin
                waited++;
                if (waited > 200) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", waited);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rand_in  = rnd_vec();
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || busy) && waited < 500) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 500) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] d_s1 [4] = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF,
                               64'h0123_4567_89AB_CDEF, 64'h5A5A_1234_C3C3_9876};
    logic [W-1:0] d_s2 [4] = '{64'h0, 64'hF0F0_F0F0_F0F0_F0F0,
                               64'h0, 64'h5A5A_1234_C3C3_9876};
    logic [W-1:0] d_exp [4] = '{64'hBF32_AC91_6780_E5D4, 64'hB4B4_B4B4_B4B4_B4B4,
                                64'hBF32_AC91_6780_E5D4, 64'hBBBB_BBBB_BBBB_BBBB};

    bit tog_done;

    initial begin
        int c0;
        int a0;
        int o0;
        bit snap;
        logic [W-1:0] h1, h2;
        logic [W-1:0] s1, s2;
        logic [7:0]   p;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_share1 = '0;
        in_share2 = '0;
        rand_in   = '0;
        out_ready = 1'b1;
        cur_exp   = '0;
        last_o1   = '0;
        last_o2   = '0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, '0);
        chk("rst_busy",      {63'd0, busy},      '0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_share1",    out_share1,         '0);
        chk("rst_share2",    out_share2,         '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single vector, all zero: out_valid exactly two cycles after acceptance.
        in_valid  = 1'b1;
        in_share1 = '0;
        in_share2 = '0;
        rand_in   = '0;
        cur_exp   = 64'hBBBB_BBBB_BBBB_BBBB;
        @(negedge clk);
        chk("single_accept", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_valid", {63'd0, out_valid}, '0);
        @(negedge clk);
        chk("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
        wait_idle();

        // Idle-stage share behaviour after the pipeline empties.
        repeat (2) @(posedge clk);
        #1;
`ifdef PRINCE_SBOX_IDLE_CLR_EN
        chk("idle_share1", out_share1, '0);
        chk("idle_share2", out_share2, '0);
`else
        chk("idle_share1", out_share1, last_o1);
        chk("idle_share2", out_share2, last_o2);
`endif

        // Directed vectors with hand-computed results, random masks.
        for (int i = 0; i < 4; i++) send(d_s1[i], d_s2[i], rnd_vec(), d_exp[i]);
        wait_idle();

        // Full 256-pair sweep, staggered per channel, one vector per cycle.
        c0 = cyc;
        for (int v = 0; v < 256; v++) begin
            s1 = '0;
            s2 = '0;
            for (int i = 0; i < NCH; i++) begin
                p = 8'(v + 17*i);
                s1[4*i +: 4] = p[7:4];
                s2[4*i +: 4] = p[3:0];
            end
            send(s1, s2, rnd_vec(), model(s1, s2));
        end
        chk("throughput_cycles", 64'(cyc - c0), 64'd256);
        wait_idle();

        // Backpressure: 0..7 flowing, then a stall while 8..F are offered.
        o0 = n_out;
        for (int v = 0; v < 8; v++) send({16{4'(v)}}, '0, rnd_vec(), model({16{4'(v)}}, '0));
        wait_idle();
        out_ready = 1'b0;
        a0 = n_acc;
        fork
            begin
                for (int v = 8; v < 16; v++) send({16{4'(v)}}, {16{4'h3}}, rnd_vec(), model({16{4'(v)}}, {16{4'h3}}));
            end
            begin
                snap = 0;
                h1 = '0;
                h2 = '0;
                for (int c = 0; c < 7; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (!snap) begin
                            snap = 1;
                            h1 = out_share1;
                            h2 = out_share2;
                        end else begin
                            chk("stall_hold_s1", out_share1, h1);
                            chk("stall_hold_s2", out_share2, h2);
                        end
                    end
                end
                #1;
                chk("stall_valid",    {63'd0, out_valid}, 64'd1);
                chk("stall_in_ready", {63'd0, in_ready},  '0);
                chk("stall_accepts",  64'(n_acc - a0),    64'd2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_idle();
        chk("stream_count", 64'(n_out - o0), 64'd16);

        // Random downstream stalls while streaming.
        tog_done = 0;
        fork
            begin
                for (int v = 0; v < 40; v++) begin
                    s1 = {$urandom(), $urandom()};
                    s2 = {$urandom(), $urandom()};
                    send(s1, s2, rnd_vec(), model(s1, s2));
                end
                tog_done = 1;
            end
            begin
                while (!tog_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_idle();

        // Reset with both stages full.
        out_ready = 1'b0;
        send(64'h1111_2222_3333_4444, '0, rnd_vec(), model(64'h1111_2222_3333_4444, '0));
        send(64'h5555_6666_7777_8888, '0, rnd_vec(), model(64'h5555_6666_7777_8888, '0));
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_out_valid", {63'd0, out_valid}, '0);
        chk("mid_rst_busy",      {63'd0, busy},      '0);
        chk("mid_rst_share1",    out_share1,         '0);
        chk("mid_rst_share2",    out_share2,         '0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_quiet", {63'd0, out_valid}, '0);
        send(64'hCAFE_F00D_1234_5678, 64'h0F0F_0F0F_0F0F_0F0F, rnd_vec(),
             model(64'hCAFE_F00D_1234_5678, 64'h0F0F_0F0F_0F0F_0F0F));
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
